// File: rtl/prog_mem.sv
// prog_mem: writable program memory for the Fibonacci processor.
// After reset (or a boot request) the built-in boot program is copied into
// the array one word per cycle; afterwards the block serves registered
// fetches and host writes.
//
// state  | meaning
// S_INIT | copying boot word r_init_cnt into the array; fetch/write ignored
// S_RUN  | ready; fetches and host writes are served
module prog_mem #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_boot_req,
  output logic              o_ready,
  input  logic              i_fetch_en,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_oob_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_init_last;
  logic              w_run_ok;
  logic              w_fetch_inr;
  logic              w_wr_inr;
  logic [IDX_W-1:0]  w_fetch_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_init_idx;

  // Boot program, 12-bit words zero-extended to DATA_W.
  function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] idx);
    logic [11:0] w;
    case (int'(idx))
      0:       w = 12'h800;
      1:       w = 12'h600;
      2:       w = 12'h801;
      3:       w = 12'h601;
      4:       w = 12'h700;
      5:       w = 12'h001;
      6:       w = 12'h602;
      7:       w = 12'h701;
      8:       w = 12'h600;
      9:       w = 12'h702;
      10:      w = 12'h601;
      11:      w = 12'hA00;
      12:      w = 12'h404;
      default: w = 12'h000;
    endcase
    return DATA_W'(w);
  endfunction

  // Range checks are done on the full address so nothing aliases modulo DEPTH.
  assign w_init_last = (r_init_cnt == ADDR_W'(DEPTH - 1));
  assign w_run_ok    = (r_state == S_RUN) && !i_boot_req;
  assign w_fetch_inr = ({1'b0, i_fetch_addr} < (ADDR_W + 1)'(DEPTH));
  assign w_wr_inr    = ({1'b0, i_wr_addr} < (ADDR_W + 1)'(DEPTH));
  assign w_fetch_idx = i_fetch_addr[IDX_W-1:0];
  assign w_wr_idx    = i_wr_addr[IDX_W-1:0];
  assign w_init_idx  = r_init_cnt[IDX_W-1:0];
  assign o_ready     = (r_state == S_RUN);

  // State and init counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_cnt_nxt;
    end
  end

  // Next-state logic: INIT walks the whole array once, boot_req re-enters INIT.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_init_cnt;
    case (r_state)
      S_INIT: begin
        if (w_init_last) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_init_cnt + ADDR_W'(1);
        end
      end
      S_RUN: begin
        if (i_boot_req) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Array write port: boot copy during INIT, in-range host writes in RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (r_state == S_INIT) begin
        r_mem[w_init_idx] <= boot_word(r_init_cnt);
      end else if (w_run_ok && i_wr_en && w_wr_inr) begin
        r_mem[w_wr_idx] <= i_wr_data;
      end
    end
  end

  // Registered fetch data and status pulses; reads see the pre-write word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
      o_wr_ack   <= 1'b0;
      o_oob_err  <= 1'b0;
    end else begin
      o_rd_valid <= 1'b0;
      o_wr_ack   <= 1'b0;
      o_oob_err  <= 1'b0;
      if (w_run_ok) begin
        if (i_fetch_en) begin
          o_rd_valid <= 1'b1;
          o_rd_data  <= w_fetch_inr ? r_mem[w_fetch_idx] : '0;
        end
        if ((i_fetch_en && !w_fetch_inr) || (i_wr_en && !w_wr_inr)) begin
          o_oob_err <= 1'b1;
        end
        if (i_wr_en && w_wr_inr) begin
          o_wr_ack <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: a default instance (A) and a small DEPTH=10 instance (B)
// checked against an array model of the memory contents.
module tb_prog_mem;
  localparam int A_D = 256;
  localparam int B_D = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_boot, a_fe, a_we, a_ready, a_rv, a_ack, a_oob;
  logic [7:0]  a_fa, a_wa;
  logic [11:0] a_wd, a_rd;
  logic b_boot, b_fe, b_we, b_ready, b_rv, b_ack, b_oob;
  logic [3:0]  b_fa, b_wa;
  logic [15:0] b_wd, b_rd;

  prog_mem #(.DATA_W(12), .ADDR_W(8), .DEPTH(A_D)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_boot_req(a_boot), .o_ready(a_ready),
    .i_fetch_en(a_fe), .i_fetch_addr(a_fa), .o_rd_data(a_rd), .o_rd_valid(a_rv),
    .i_wr_en(a_we), .i_wr_addr(a_wa), .i_wr_data(a_wd), .o_wr_ack(a_ack),
    .o_oob_err(a_oob));

  prog_mem #(.DATA_W(16), .ADDR_W(4), .DEPTH(B_D)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_boot_req(b_boot), .o_ready(b_ready),
    .i_fetch_en(b_fe), .i_fetch_addr(b_fa), .o_rd_data(b_rd), .o_rd_valid(b_rv),
    .i_wr_en(b_we), .i_wr_addr(b_wa), .i_wr_data(b_wd), .o_wr_ack(b_ack),
    .o_oob_err(b_oob));

  int checks = 0;
  int failures = 0;

  logic [15:0] boot_tbl [13];
  logic [15:0] mdl_a [A_D];
  logic [15:0] mdl_b [B_D];
  logic [15:0] last_a, last_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void load_a();
    for (int i = 0; i < A_D; i++) mdl_a[i] = (i < 13) ? boot_tbl[i] : 16'h0;
  endfunction

  function automatic void load_b();
    for (int i = 0; i < B_D; i++) mdl_b[i] = (i < 13) ? boot_tbl[i] : 16'h0;
  endfunction

  // One edge on instance A in RUN; expectations come from the array model.
  task automatic cyc_a(input logic fe, input logic [7:0] fa, input logic we,
                       input logic [7:0] wa, input logic [11:0] wd);
    a_fe = fe; a_fa = fa; a_we = we; a_wa = wa; a_wd = wd;
    @(posedge clk); #1;
    a_fe = 1'b0; a_we = 1'b0;
    if (fe) last_a = mdl_a[int'(fa)];
    if (we) mdl_a[int'(wa)] = {4'h0, wd};
    chk("a_ready", 32'(a_ready), 32'(1));
    chk("a_rd_valid", 32'(a_rv), 32'(fe));
    chk("a_rd_data", 32'(a_rd), 32'(last_a));
    chk("a_wr_ack", 32'(a_ack), 32'(we));
    chk("a_oob_err", 32'(a_oob), 32'(0));
  endtask

  // One edge on instance B in RUN, including out-of-range handling.
  task automatic cyc_b(input logic fe, input logic [3:0] fa, input logic we,
                       input logic [3:0] wa, input logic [15:0] wd);
    logic fin, win;
    b_fe = fe; b_fa = fa; b_we = we; b_wa = wa; b_wd = wd;
    @(posedge clk); #1;
    b_fe = 1'b0; b_we = 1'b0;
    fin = (int'(fa) < B_D);
    win = (int'(wa) < B_D);
    if (fe) last_b = fin ? mdl_b[int'(fa)] : 16'h0;
    if (we && win) mdl_b[int'(wa)] = wd;
    chk("b_rd_valid", 32'(b_rv), 32'(fe));
    chk("b_rd_data", 32'(b_rd), 32'(last_b));
    chk("b_wr_ack", 32'(b_ack), 32'(we && win));
    chk("b_oob_err", 32'(b_oob), 32'((fe && !fin) || (we && !win)));
  endtask

  task automatic chk_reset_outs();
    chk("rst_a_ready", 32'(a_ready), 32'(0));
    chk("rst_a_rv", 32'(a_rv), 32'(0));
    chk("rst_a_rd", 32'(a_rd), 32'(0));
    chk("rst_a_ack", 32'(a_ack), 32'(0));
    chk("rst_a_oob", 32'(a_oob), 32'(0));
    chk("rst_b_ready", 32'(b_ready), 32'(0));
    chk("rst_b_rv", 32'(b_rv), 32'(0));
    chk("rst_b_rd", 32'(b_rd), 32'(0));
    chk("rst_b_ack", 32'(b_ack), 32'(0));
    chk("rst_b_oob", 32'(b_oob), 32'(0));
  endtask

  // Counts edges until each instance raises ready (0 means the bound expired).
  task automatic wait_ready(output int na, output int nb);
    na = 0; nb = 0;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clk); #1;
      if (a_ready && na == 0) na = n;
      if (b_ready && nb == 0) nb = n;
      if (na != 0 && nb != 0) break;
    end
  endtask

  int na, nb, leak;
  logic [7:0] fa, wa;

  initial begin
    boot_tbl = '{16'h800, 16'h600, 16'h801, 16'h601, 16'h700, 16'h001, 16'h602,
                 16'h701, 16'h600, 16'h702, 16'h601, 16'hA00, 16'h404};
    rst_n = 1'b0;
    a_boot = 0; a_fe = 0; a_we = 0; a_fa = '0; a_wa = '0; a_wd = '0;
    b_boot = 0; b_fe = 0; b_we = 0; b_fa = '0; b_wa = '0; b_wd = '0;
    last_a = 16'h0; last_b = 16'h0;

    // Reset and initial boot copy
    @(posedge clk); @(posedge clk); #1;
    chk_reset_outs();
    rst_n = 1'b1;
    wait_ready(na, nb);
    chk("init_len_a", 32'(na), 32'(A_D));
    chk("init_len_b", 32'(nb), 32'(B_D));
    load_a(); load_b();

    // Single fetches with idle cycles between, plus spec constants
    cyc_a(1, 8'h00, 0, 8'h00, 12'h0); chk("fetch_00", 32'(a_rd), 32'h800);
    cyc_a(0, 8'h00, 0, 8'h00, 12'h0);
    cyc_a(1, 8'h05, 0, 8'h00, 12'h0); chk("fetch_05", 32'(a_rd), 32'h001);
    cyc_a(0, 8'h00, 0, 8'h00, 12'h0);
    cyc_a(1, 8'h0C, 0, 8'h00, 12'h0); chk("fetch_0c", 32'(a_rd), 32'h404);
    cyc_a(0, 8'h00, 0, 8'h00, 12'h0);
    cyc_a(1, 8'h0D, 0, 8'h00, 12'h0); chk("fetch_0d", 32'(a_rd), 32'h000);
    cyc_a(0, 8'h00, 0, 8'h00, 12'h0);

    // Back-to-back fetches of the whole boot program
    for (int i = 0; i < 13; i++) begin
      cyc_a(1, 8'(i), 0, 8'h00, 12'h0);
      chk("b2b_prog", 32'(a_rd), 32'(boot_tbl[i]));
    end
    cyc_a(0, 8'h00, 0, 8'h00, 12'h0);

    // Same-edge write and fetch: read-first
    cyc_a(1, 8'h05, 1, 8'h05, 12'hFFF); chk("rw_first_old", 32'(a_rd), 32'h001);
    cyc_a(1, 8'h05, 0, 8'h00, 12'h0);   chk("rw_first_new", 32'(a_rd), 32'hFFF);

    // Boot reload: fetch/write on the boot edge and during INIT are ignored
    cyc_a(0, 8'h00, 1, 8'h05, 12'h123);
    a_boot = 1; a_fe = 1; a_fa = 8'h05; a_we = 1; a_wa = 8'h06; a_wd = 12'hABC;
    @(posedge clk); #1;
    a_boot = 0; a_fe = 0; a_we = 0;
    chk("boot_ready_low", 32'(a_ready), 32'(0));
    chk("boot_edge_rv", 32'(a_rv), 32'(0));
    chk("boot_edge_ack", 32'(a_ack), 32'(0));
    load_a();
    na = 0; leak = 0;
    for (int n = 1; n <= 600; n++) begin
      a_fe = 1; a_fa = 8'($urandom); a_we = 1; a_wa = 8'($urandom); a_wd = 12'($urandom);
      a_boot = (n == 50);
      @(posedge clk); #1;
      if (a_rv || a_ack || a_oob) leak++;
      if (a_ready) begin na = n; break; end
    end
    a_fe = 0; a_we = 0; a_boot = 0;
    chk("reboot_len", 32'(na), 32'(A_D));
    chk("init_ignores_io", 32'(leak), 32'(0));
    cyc_a(1, 8'h05, 0, 8'h00, 12'h0); chk("reboot_05", 32'(a_rd), 32'h001);
    cyc_a(1, 8'h06, 0, 8'h00, 12'h0); chk("reboot_06", 32'(a_rd), 32'h602);

    // Small instance: truncated program and out-of-range accesses
    cyc_b(1, 4'd9, 0, 4'd0, 16'h0);   chk("b_fetch9", 32'(b_rd), 32'h0702);
    cyc_b(1, 4'd12, 0, 4'd0, 16'h0);  chk("b_oob_fetch", 32'(b_oob), 32'(1));
    cyc_b(0, 4'd0, 1, 4'd15, 16'hBEEF); chk("b_oob_wr_ack", 32'(b_ack), 32'(0));
    cyc_b(1, 4'd13, 1, 4'd14, 16'h1234);
    cyc_b(0, 4'd0, 0, 4'd0, 16'h0);
    cyc_b(1, 4'd9, 0, 4'd0, 16'h0);   chk("b_oob_no_wrap", 32'(b_rd), 32'h0702);

    // Randomized traffic against the array models
    for (int i = 0; i < 300; i++) begin
      fa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      wa = ($urandom_range(0, 3) == 0) ? fa : 8'($urandom_range(0, 15));
      cyc_a(1'($urandom), fa, 1'($urandom), wa, 12'($urandom));
    end
    for (int i = 0; i < 300; i++) begin
      cyc_b(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 16'($urandom));
    end

    // Reset at INIT cycle 100 restarts the full count
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin @(posedge clk); #1; end
    rst_n = 1'b0; @(posedge clk); #1;
    chk_reset_outs();
    rst_n = 1'b1;
    wait_ready(na, nb);
    chk("mid_init_len_a", 32'(na), 32'(A_D));
    chk("mid_init_len_b", 32'(nb), 32'(B_D));
    load_a(); load_b(); last_a = 16'h0; last_b = 16'h0;

    // Reset in RUN overrides a simultaneous fetch/write
    cyc_a(1, 8'h00, 1, 8'h20, 12'h555);
    cyc_b(1, 4'd9, 0, 4'd0, 16'h0);
    rst_n = 1'b0; a_fe = 1; a_fa = 8'h00; a_we = 1; a_wa = 8'h21; a_wd = 12'h777;
    b_fe = 1; b_fa = 4'd12;
    @(posedge clk); #1;
    a_fe = 0; a_we = 0; b_fe = 0;
    chk_reset_outs();
    rst_n = 1'b1;
    wait_ready(na, nb);
    chk("mid_run_len_a", 32'(na), 32'(A_D));
    chk("mid_run_len_b", 32'(nb), 32'(B_D));
    load_a(); load_b(); last_a = 16'h0; last_b = 16'h0;
    cyc_a(1, 8'h20, 0, 8'h00, 12'h0); chk("rst_reload_20", 32'(a_rd), 32'h000);
    cyc_a(1, 8'h0B, 0, 8'h00, 12'h0); chk("rst_reload_0b", 32'(a_rd), 32'hA00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
